// File: rtl/bpred_pkg.sv
// Shared types and helpers for the gshare/bimodal branch predictor.
// Counter helpers work on 4-bit values; callers truncate to CTR_BITS.
package bpred_pkg;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} bpred_state_e;

  function automatic logic [3:0] ctr_wnt(input int ctr_bits);
    return 4'((1 << (ctr_bits - 1)) - 1);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input int ctr_bits);
    logic [3:0] mx;
    mx = 4'((1 << ctr_bits) - 1);
    return (v == mx) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] v, input int ctr_bits);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction

  // Word-aligned PC bits, optionally folded with zero-extended history.
  function automatic logic [31:0] idx_hash(input logic [31:0] pc, input logic [31:0] ghr_ext,
                                           input int addr_bits, input bit gshare);
    logic [31:0] mask;
    logic [31:0] pc_idx;
    mask   = (32'd1 << addr_bits) - 32'd1;
    pc_idx = (pc >> 2) & mask;
    return gshare ? ((pc_idx ^ ghr_ext) & mask) : pc_idx;
  endfunction

endpackage

// File: rtl/bpred_table.sv
// Saturating counter table with a walking initialiser. The single write port is
// owned by the walker in INIT and by resolved-branch updates in RUN.
module bpred_table
  import bpred_pkg::*;
#(
  parameter int ADDR_BITS = 4,
  parameter int CTR_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] rd_idx,
  output logic                 rd_taken,
  input  logic                 upd_valid,
  input  logic [ADDR_BITS-1:0] upd_idx,
  input  logic                 upd_taken,
  output logic                 ready
);

  localparam int ENTRIES = 1 << ADDR_BITS;
  localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'(ctr_wnt(CTR_BITS));

  bpred_state_e          state_q, state_d;
  logic [ADDR_BITS-1:0]  ptr_q, ptr_d;
  logic [CTR_BITS-1:0]   tbl_q [ENTRIES];

  logic                  wr_en;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [CTR_BITS-1:0]   wr_data;
  logic [3:0]            cur;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_addr = upd_idx;
    wr_data = WNT;
    cur     = 4'(tbl_q[upd_idx]);
    case (state_q)
      ST_INIT: begin
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        ptr_d   = ptr_q + ADDR_BITS'(1);
        if (ptr_q == ADDR_BITS'(ENTRIES - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (upd_valid) begin
          wr_en   = 1'b1;
          wr_data = upd_taken ? CTR_BITS'(sat_inc(cur, CTR_BITS))
                              : CTR_BITS'(sat_dec(cur, CTR_BITS));
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Contents need no reset: the walker rewrites every entry after reset.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) tbl_q[wr_addr] <= wr_data;
  end

  assign rd_taken = tbl_q[rd_idx][CTR_BITS-1];
  assign ready    = (state_q == ST_RUN);

endmodule

// File: rtl/bpred_gshare.sv
// Branch direction predictor: index hashing, global history, statistics and
// output gating around the counter table.
module bpred_gshare
  import bpred_pkg::*;
#(
  parameter int BHT_ADDR_BITS = 4,
  parameter int CTR_BITS      = 2,
  parameter int GHR_BITS      = 4,
  parameter int HASH_MODE     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic [31:0]              pred_pc,
  output logic                     pred_taken,
  output logic [BHT_ADDR_BITS-1:0] pred_index,
  input  logic                     upd_valid,
  input  logic [BHT_ADDR_BITS-1:0] upd_index,
  input  logic                     upd_taken,
  input  logic                     upd_predicted,
  output logic [GHR_BITS-1:0]      ghr,
  output logic [31:0]              stat_branches,
  output logic [31:0]              stat_hits
);

  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         stat_branches_q, stat_branches_d;
  logic [31:0]         stat_hits_q, stat_hits_d;
  logic                tbl_ready;
  logic                tbl_taken;
  logic                upd_en;

  bpred_table #(
    .ADDR_BITS (BHT_ADDR_BITS),
    .CTR_BITS  (CTR_BITS)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (pred_index),
    .rd_taken  (tbl_taken),
    .upd_valid (upd_valid),
    .upd_idx   (upd_index),
    .upd_taken (upd_taken),
    .ready     (tbl_ready)
  );

  assign pred_index = BHT_ADDR_BITS'(idx_hash(pred_pc, 32'(ghr_q), BHT_ADDR_BITS, HASH_MODE != 0));
  assign upd_en     = upd_valid & tbl_ready;

  always_comb begin
    ghr_d           = ghr_q;
    stat_branches_d = stat_branches_q;
    stat_hits_d     = stat_hits_q;
    if (upd_en) begin
      // Truncation drops the oldest bit; also covers the 1-bit history case.
      ghr_d           = GHR_BITS'({ghr_q, upd_taken});
      stat_branches_d = stat_branches_q + 32'd1;
      if (upd_taken == upd_predicted) stat_hits_d = stat_hits_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q           <= '0;
      stat_branches_q <= '0;
      stat_hits_q     <= '0;
    end else begin
      ghr_q           <= ghr_d;
      stat_branches_q <= stat_branches_d;
      stat_hits_q     <= stat_hits_d;
    end
  end

  assign ready         = tbl_ready;
  assign pred_taken    = tbl_ready & tbl_taken;
  assign ghr           = ghr_q;
  assign stat_branches = stat_branches_q;
  assign stat_hits     = stat_hits_q;

endmodule
